// File: rtl/float_mult16.sv
// float_mult16: registered IEEE-754 binary16 multiplier, round to nearest even, one-cycle latency
module float_mult16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic        out_valid,
  output logic [15:0] product
);
  logic               signA, signB, signR;
  logic [4:0]         expA, expB, effA, effB;
  logic [9:0]         fracA, fracB;
  logic               nanA, nanB, infA, infB, zeroA, zeroB;
  logic [10:0]        sigA, sigB;
  logic [21:0]        rawProd, normProd, shifted;
  logic [4:0]         lead;
  logic signed [7:0]  expNorm, expFinal;
  logic [5:0]         denormShift;
  logic               lostBits, guardBit, roundBit, stickyBit, roundUp;
  logic [10:0]        mant;
  logic [11:0]        rounded;
  logic [15:0]        finite, result;

  assign {signA, expA, fracA} = floatA;
  assign {signB, expB, fracB} = floatB;
  assign signR = signA ^ signB;
  assign nanA  = &expA && |fracA;
  assign nanB  = &expB && |fracB;
  assign infA  = &expA && ~|fracA;
  assign infB  = &expB && ~|fracB;
  assign zeroA = ~|expA && ~|fracA;
  assign zeroB = ~|expB && ~|fracB;
  // subnormals lack the hidden one but share the exponent of the smallest normal
  assign sigA  = {|expA, fracA};
  assign sigB  = {|expB, fracB};
  assign effA  = |expA ? expA : 5'd1;
  assign effB  = |expB ? expB : 5'd1;
  assign rawProd = 22'(sigA) * 22'(sigB);

  // leading-one position of the raw 22-bit significand product
  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 22; i++) if (rawProd[i]) lead = 5'(i);
  end

  // normalize so the leading one sits at bit 21, then denormalize, round and pack
  always_comb begin
    normProd    = rawProd << (5'd21 - lead);
    expNorm     = 8'(effA) + 8'(effB) + 8'(lead) - 8'd35;
    denormShift = expNorm <= 8'sd0 ? 6'(8'sd1 - expNorm) : 6'd0;
    shifted     = normProd >> denormShift;
    lostBits    = |(normProd & ~({22{1'b1}} << denormShift));
    mant        = shifted[21:11];
    guardBit    = shifted[10];
    roundBit    = shifted[9];
    stickyBit   = |shifted[8:0] || lostBits;
    roundUp     = guardBit && (roundBit || stickyBit || mant[0]);
    rounded     = {1'b0, mant} + 12'(roundUp);
    expFinal    = expNorm + 8'(rounded[11]);
    finite      = expNorm <= 8'sd0 ? {signR, 4'd0, rounded[10:0]} :
                  expFinal >= 8'sd31 ? {signR, 5'h1F, 10'd0} :
                  {signR, expFinal[4:0], rounded[9:0]};
    result      = nanA || nanB ? 16'h7E00 :
                  (infA && zeroB) || (infB && zeroA) ? 16'h7E00 :
                  infA || infB ? {signR, 5'h1F, 10'd0} :
                  zeroA || zeroB ? {signR, 15'd0} : finite;
  end

  // output register: capture a product per accepted pair, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product   <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) product <= result;
    end
  end
endmodule

// File: tb/tb_float_mult16.sv
// tb_float_mult16: scoreboard bench for float_mult16 with directed hand-computed vectors
module tb_float_mult16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] floatA = 16'h0000;
  logic [15:0] floatB = 16'h0000;
  logic        out_valid;
  logic [15:0] product;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] want;
    int          due;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;

  float_mult16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .floatA(floatA),
    .floatB(floatB), .out_valid(out_valid), .product(product)
  );

  always #5 clk = ~clk;

  // cycle counter used to check the one-cycle latency
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare every presented result against the oldest expected one
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: product=%h out_valid=1, required no output", product);
      end else begin
        item_t it;
        it = q.pop_front();
        if (product !== it.want || cyc != it.due) begin
          fails++;
          $display("FAIL mul %h*%h: got %h at cycle %0d, required %h at cycle %0d",
                   it.a, it.b, product, cyc, it.want, it.due);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want);
    item_t it;
    @(negedge clk);
    in_valid = 1'b1;
    floatA = a;
    floatB = b;
    it.a = a;
    it.b = b;
    it.want = want;
    it.due = cyc + 1;
    q.push_back(it);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  initial begin
    @(negedge clk);
    in_valid = 1'b1;
    floatA = 16'h4400;
    floatB = 16'h4500;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", {out_valid, product}, 17'h00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    send(16'h4400, 16'h4500, 16'h4D00);
    idle();
    send(16'h3C00, 16'hC000, 16'hC000);
    idle();
    send(16'h0EC2, 16'h0000, 16'h0000);
    send(16'h8000, 16'h4400, 16'h8000);
    send(16'h3C01, 16'h3C01, 16'h3C02);
    send(16'h7BFF, 16'h7BFF, 16'h7C00);
    send(16'h0001, 16'h3C00, 16'h0001);
    send(16'h0001, 16'h0001, 16'h0000);
    send(16'h7C00, 16'h0000, 16'h7E00);
    send(16'h0000, 16'h7C00, 16'h7E00);
    send(16'h7C00, 16'hC000, 16'hFC00);
    send(16'h7E01, 16'h3C00, 16'h7E00);
    send(16'h03FF, 16'h4000, 16'h07FE);
    send(16'h3555, 16'h3E00, 16'h3800);
    idle();
    idle();
    send(16'h4400, 16'h4500, 16'h4D00);
    send(16'h3C00, 16'hC000, 16'hC000);
    send(16'h0000, 16'h4200, 16'h0000);
    idle();
    @(posedge clk);
    #1;
    check("hold", {out_valid, product}, 17'h00000);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
